// File: rtl/rega_pkg.sv
// Shared definitions for the irrigation actuator: FSM state encoding,
// request codes and a small helper for sizing the shared timer.
package rega_pkg;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        ABRINDO  = 3'd1,
        REGANDO  = 3'd2,
        FECHANDO = 3'd3,
        FALHA    = 3'd4
    } estado_t;

    localparam logic [1:0] REGA_NENHUM = 2'b00;
    localparam logic [1:0] REGA_GOT    = 2'b01;
    localparam logic [1:0] REGA_ASP    = 2'b10;
    localparam logic [1:0] REGA_INV    = 2'b11;

    // Larger of two durations; used to size the single shared timer.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/temporizador_rega.sv
// Loadable down-counter that holds at zero. The owning FSM loads D-1 on
// entry to a state of duration D and leaves that state when zero is high.
module temporizador_rega #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             carga,
    input  logic [WIDTH-1:0] valor,
    output logic             zero
);

    logic [WIDTH-1:0] cont_q;

    // Load takes precedence over counting; the count parks at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cont_q <= '0;
        end else if (carga) begin
            cont_q <= valor;
        end else if (cont_q != '0) begin
            cont_q <= cont_q - 1'b1;
        end
    end

    assign zero = (cont_q == '0);

endmodule

// File: rtl/atuador_rega.sv
// Timed irrigation actuator: opens the selected valve, runs the pump for a
// mode-dependent time, drains, and closes. Any validation error locks the
// block into FALHA until a run of clean cycles is observed.
// Build option: define ATUADOR_CONTADOR_EN to get a saturating 8-bit count
// of completed cycles on ciclos; otherwise ciclos is constant zero.
module atuador_rega
    import rega_pkg::*;
#(
    parameter int T_ABRE     = 4,
    parameter int T_REGA_ASP = 100,
    parameter int T_REGA_GOT = 60,
    parameter int T_FECHA    = 3,
    parameter int T_RETRY    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] rega,
    input  logic       erro,
    input  logic       limpeza,
    output logic       valv_asp,
    output logic       valv_got,
    output logic       bomba,
    output logic       regando,
    output logic       falha,
    output logic       fim_ciclo,
    output logic [7:0] ciclos
);

    localparam int T_MAX = max2(max2(max2(T_ABRE, T_REGA_ASP), max2(T_REGA_GOT, T_FECHA)), T_RETRY);
    localparam int WT    = (T_MAX < 2) ? 1 : $clog2(T_MAX + 1);

    localparam logic [WT-1:0] V_ABRE  = WT'(T_ABRE - 1);
    localparam logic [WT-1:0] V_ASP   = WT'(T_REGA_ASP - 1);
    localparam logic [WT-1:0] V_GOT   = WT'(T_REGA_GOT - 1);
    localparam logic [WT-1:0] V_FECHA = WT'(T_FECHA - 1);
    localparam logic [WT-1:0] V_RETRY = WT'(T_RETRY - 1);

    estado_t       estado_q, estado_d;
    logic [1:0]    modo_q, modo_d;
    logic          aborto_q, aborto_d;
    logic          fim_q, fim_d;
    logic          carga;
    logic [WT-1:0] valor;
    logic          zero;

    temporizador_rega #(
        .WIDTH (WT)
    ) u_temp (
        .clk   (clk),
        .reset (reset),
        .carga (carga),
        .valor (valor),
        .zero  (zero)
    );

    // Next-state, mode/abort latching and timer load requests.
    always_comb begin
        estado_d = estado_q;
        modo_d   = modo_q;
        aborto_d = aborto_q;
        fim_d    = 1'b0;
        carga    = 1'b0;
        valor    = '0;
        unique case (estado_q)
            OCIOSO: begin
                if (erro || rega == REGA_INV) begin
                    estado_d = FALHA;
                    carga    = 1'b1;
                    valor    = V_RETRY;
                end else if ((rega == REGA_ASP || rega == REGA_GOT) && !limpeza) begin
                    estado_d = ABRINDO;
                    modo_d   = rega;
                    carga    = 1'b1;
                    valor    = V_ABRE;
                end
            end
            ABRINDO: begin
                if (erro || limpeza || rega != modo_q) begin
                    estado_d = FECHANDO;
                    aborto_d = 1'b1;
                    carga    = 1'b1;
                    valor    = V_FECHA;
                end else if (zero) begin
                    estado_d = REGANDO;
                    carga    = 1'b1;
                    valor    = (modo_q == REGA_ASP) ? V_ASP : V_GOT;
                end
            end
            REGANDO: begin
                // Error, invalid code or a switch of mode is an abnormal stop;
                // a withdrawn request, cleaning or timeout is a clean stop.
                if (erro || rega == REGA_INV || (rega != REGA_NENHUM && rega != modo_q)) begin
                    estado_d = FECHANDO;
                    aborto_d = 1'b1;
                    carga    = 1'b1;
                    valor    = V_FECHA;
                end else if (rega == REGA_NENHUM || limpeza || zero) begin
                    estado_d = FECHANDO;
                    aborto_d = 1'b0;
                    carga    = 1'b1;
                    valor    = V_FECHA;
                end
            end
            FECHANDO: begin
                // The drain always completes; erro only decides where it ends.
                if (zero) begin
                    if (erro || aborto_q) begin
                        estado_d = FALHA;
                        carga    = 1'b1;
                        valor    = V_RETRY;
                    end else begin
                        estado_d = OCIOSO;
                        fim_d    = 1'b1;
                    end
                end
            end
            FALHA: begin
                if (erro || rega != REGA_NENHUM) begin
                    carga = 1'b1;
                    valor = V_RETRY;
                end else if (zero) begin
                    estado_d = OCIOSO;
                    aborto_d = 1'b0;
                    modo_d   = REGA_NENHUM;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // FSM state, latched mode, abort flag and registered completion pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= OCIOSO;
            modo_q   <= REGA_NENHUM;
            aborto_q <= 1'b0;
            fim_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            modo_q   <= modo_d;
            aborto_q <= aborto_d;
            fim_q    <= fim_d;
        end
    end

    logic ativo;
    assign ativo     = (estado_q == ABRINDO) || (estado_q == REGANDO) || (estado_q == FECHANDO);
    assign valv_asp  = ativo && (modo_q == REGA_ASP);
    assign valv_got  = ativo && (modo_q == REGA_GOT);
    assign bomba     = (estado_q == REGANDO) && (modo_q == REGA_ASP || modo_q == REGA_GOT);
    assign regando   = ativo;
    assign falha     = (estado_q == FALHA);
    assign fim_ciclo = fim_q;

`ifdef ATUADOR_CONTADOR_EN
    logic [7:0] ciclos_q;

    // Completed-cycle count, saturating at 255, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ciclos_q <= 8'd0;
        end else if (fim_d && ciclos_q != 8'hFF) begin
            ciclos_q <= ciclos_q + 8'd1;
        end
    end

    assign ciclos = ciclos_q;
`else
    assign ciclos = 8'd0;
`endif

endmodule
